// File: rtl/decmpp_pkg.sv
// decmpp_pkg: shared constants and range helpers
// for the generalised MPP reconstruction datapath.
package decmpp_pkg;

   localparam int QW         = 8;
   localparam int BLK        = 16;
   localparam int SSM0_LANES = 4;

   // First-line midpoint: mid-range if unsigned, zero if signed.
   function automatic int fls_mp(int depth, bit sgn);
      return sgn ? 0 : (1 << (depth - 1));
   endfunction

   function automatic int clip_lo(int depth, bit sgn);
      return sgn ? -(1 << (depth - 1)) : 0;
   endfunction

   function automatic int clip_hi(int depth, bit sgn);
      return sgn ? (1 << (depth - 1)) - 1 : (1 << depth) - 1;
   endfunction

endpackage

// File: rtl/decmpp_lane.sv
// decmpp_lane: one component's midpoint, dequant and clip.
// Two register stages; load enables come from the top.
module decmpp_lane
   import decmpp_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter bit IS_CHROMA = 1'b0
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 ld1,
   input  logic                 ld2,
   input  logic                 is_fls,
   input  logic                 csc_ycocg,
   input  logic                 s1_ycocg,
   input  logic [2:0]           s1_step,
   input  logic [BLK*QW-1:0]    qres,
   input  logic [BLK*DEPTH-1:0] prev,
   output logic [BLK*DEPTH-1:0] rec
);

   localparam int SW = DEPTH + 5;
   localparam int MW = DEPTH + 1;
   localparam int VW = DEPTH + 12;

   logic                 sgn_in;
   logic                 sgn1;
   logic signed [SW-1:0] sum;
   logic signed [MW-1:0] mp_in;
   logic signed [MW-1:0] mp1;
   logic [BLK*QW-1:0]    q1;
   logic [BLK*DEPTH-1:0] rec_d;
   logic signed [QW-1:0] q;
   logic signed [VW-1:0] v;
   int                   lo;
   int                   hi;

   assign sgn_in = IS_CHROMA & csc_ycocg;
   assign sgn1   = IS_CHROMA & s1_ycocg;

   // Sum previous block, sign- or zero-extending each sample.
   always_comb begin
      sum = '0;
      for (int n = 0; n < BLK; n++) begin
         if (sgn_in)
            sum = sum + {{5{prev[n*DEPTH+DEPTH-1]}},
                         prev[n*DEPTH +: DEPTH]};
         else
            sum = sum + {5'b0, prev[n*DEPTH +: DEPTH]};
      end
      mp_in = is_fls ? MW'(fls_mp(DEPTH, sgn_in))
                     : MW'(sum >>> 4);
   end

   // Stage 1: capture midpoint and residuals on accept.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mp1 <= '0;
         q1  <= '0;
      end else if (ld1) begin
         mp1 <= mp_in;
         q1  <= qres;
      end
   end

   // Dequantise each sample and clamp to the component range.
   always_comb begin
      lo    = clip_lo(DEPTH, sgn1);
      hi    = clip_hi(DEPTH, sgn1);
      rec_d = '0;
      q     = '0;
      v     = '0;
      for (int n = 0; n < BLK; n++) begin
         q = q1[n*QW +: QW];
         v = VW'(mp1) + (VW'(q) <<< s1_step);
         if (v < VW'(lo))
            v = VW'(lo);
         else if (v > VW'(hi))
            v = VW'(hi);
         rec_d[n*DEPTH +: DEPTH] = DEPTH'(v);
      end
   end

   // Stage 2: registered reconstruction.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         rec <= '0;
      else if (ld2)
         rec <= rec_d;
   end

endmodule

// File: rtl/decmpp_gen.sv
// decmpp_gen: MPP reconstruction top; substream remap,
// valid/ready control and accepted-block counter.
module decmpp_gen
   import decmpp_pkg::*;
#(
   parameter  int BPC      = 8,
   parameter  int NUM_COMP = 3,
   localparam int NUM_SSM  = NUM_COMP + 1
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        in_vld,
   output logic                        in_rdy,
   input  logic                        isFls,
   input  logic                        csc_ycocg,
   input  logic [2:0]                  mpp_step,
   input  logic [NUM_SSM*BLK*QW-1:0]   qres_ssm,
   input  logic [NUM_COMP*BLK*(BPC+1)-1:0] prev_rec,
   output logic                        out_vld,
   input  logic                        out_rdy,
   output logic [NUM_COMP*BLK*(BPC+1)-1:0] rec,
   output logic [15:0]                 blk_cnt
);

   localparam int CW = BPC + 1;

   if (NUM_COMP != 3 && NUM_COMP != 4) begin : g_bad_cfg
      $fatal(1, "decmpp_gen: NUM_COMP must be 3 or 4");
   end

   logic                          s1_vld;
   logic                          s1_ycocg;
   logic [2:0]                    s1_step;
   logic                          s2_ld;
   logic                          ld1;
   logic                          ld2;
   logic [NUM_COMP-1:0][BLK*QW-1:0] qmap;
   logic [BLK*CW-1:0]             rec_c [NUM_COMP];
   logic                          unused_in;

   assign unused_in = ^{qres_ssm, prev_rec};

   assign s2_ld  = ~out_vld | out_rdy;
   assign in_rdy = ~s1_vld | s2_ld;
   assign ld1    = in_vld & in_rdy;
   assign ld2    = s2_ld & s1_vld;

   // First lanes come from ssm0, the rest from ssm(c+1).
   always_comb begin
      qmap = '0;
      for (int c = 0; c < NUM_COMP; c++) begin
         for (int n = 0; n < BLK; n++) begin
            if (n < SSM0_LANES)
               qmap[c][n*QW +: QW] =
                  qres_ssm[(SSM0_LANES*c+n)*QW +: QW];
            else
               qmap[c][n*QW +: QW] =
                  qres_ssm[((c+1)*BLK+n-SSM0_LANES)*QW +: QW];
         end
      end
   end

   for (genvar c = 0; c < NUM_COMP; c++) begin : g_lane
      if (c == 0) begin : g_luma
         logic [BLK*BPC-1:0] p;
         logic [BLK*BPC-1:0] r;
         logic [BLK*CW-1:0]  z;

         // Luma uses only the low BPC bits of each sample.
         always_comb begin
            p = '0;
            for (int n = 0; n < BLK; n++)
               p[n*BPC +: BPC] = prev_rec[n*CW +: BPC];
         end

         decmpp_lane #(
            .DEPTH     (BPC),
            .IS_CHROMA (1'b0)
         ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .ld1       (ld1),
            .ld2       (ld2),
            .is_fls    (isFls),
            .csc_ycocg (csc_ycocg),
            .s1_ycocg  (s1_ycocg),
            .s1_step   (s1_step),
            .qres      (qmap[c]),
            .prev      (p),
            .rec       (r)
         );

         // Zero-extend luma to the common sample width.
         always_comb begin
            z = '0;
            for (int n = 0; n < BLK; n++)
               z[n*CW +: CW] = {1'b0, r[n*BPC +: BPC]};
         end

         assign rec_c[c] = z;
      end else begin : g_chroma
         decmpp_lane #(
            .DEPTH     (CW),
            .IS_CHROMA (1'b1)
         ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .ld1       (ld1),
            .ld2       (ld2),
            .is_fls    (isFls),
            .csc_ycocg (csc_ycocg),
            .s1_ycocg  (s1_ycocg),
            .s1_step   (s1_step),
            .qres      (qmap[c]),
            .prev      (prev_rec[c*BLK*CW +: BLK*CW]),
            .rec       (rec_c[c])
         );
      end
   end

   // Pack per-component results onto the output bus.
   always_comb begin
      rec = '0;
      for (int c = 0; c < NUM_COMP; c++)
         rec[c*BLK*CW +: BLK*CW] = rec_c[c];
   end

   // Pipeline valids, stage-1 side info and block counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld   <= 1'b0;
         out_vld  <= 1'b0;
         s1_ycocg <= 1'b0;
         s1_step  <= '0;
         blk_cnt  <= '0;
      end else begin
         if (ld1) begin
            s1_vld   <= 1'b1;
            s1_ycocg <= csc_ycocg;
            s1_step  <= mpp_step;
            blk_cnt  <= blk_cnt + 16'd1;
         end else if (s2_ld) begin
            s1_vld   <= 1'b0;
         end
         if (s2_ld)
            out_vld <= s1_vld;
      end
   end

endmodule

// File: tb/tb_decmpp_gen.sv
// tb_decmpp_gen: directed checks of decmpp_gen with
// BPC=8, NUM_COMP=4 against hand-computed values.
module tb_decmpp_gen;

   localparam int BPC = 8;
   localparam int NC  = 4;
   localparam int NS  = NC + 1;
   localparam int CW  = BPC + 1;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic                   in_vld;
   logic                   in_rdy;
   logic                   isFls;
   logic                   csc_ycocg;
   logic [2:0]             mpp_step;
   logic [NS*16*8-1:0]     qres_ssm;
   logic [NC*16*CW-1:0]    prev_rec;
   logic                   out_vld;
   logic                   out_rdy;
   logic [NC*16*CW-1:0]    rec;
   logic [15:0]            blk_cnt;

   int total = 0;
   int bad   = 0;

   decmpp_gen #(
      .BPC      (BPC),
      .NUM_COMP (NC)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .isFls     (isFls),
      .csc_ycocg (csc_ycocg),
      .mpp_step  (mpp_step),
      .qres_ssm  (qres_ssm),
      .prev_rec  (prev_rec),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .rec       (rec),
      .blk_cnt   (blk_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got,
                      logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] rs(int c, int n);
      return rec[(c*16+n)*CW +: CW];
   endfunction

   task automatic fill_q(logic [7:0] v);
      for (int s = 0; s < NS; s++)
         for (int j = 0; j < 16; j++)
            qres_ssm[(s*16+j)*8 +: 8] = v;
   endtask

   task automatic fill_p(int c, logic [8:0] v);
      for (int n = 0; n < 16; n++)
         prev_rec[(c*16+n)*CW +: CW] = v;
   endtask

   // Send one block with no stall and check 2-cycle latency.
   task automatic blk(string tag);
      in_vld  = 1'b1;
      out_rdy = 1'b1;
      #1;
      chk({tag, "_rdy"}, 32'(in_rdy), 1);
      @(negedge clk);
      in_vld = 1'b0;
      #1;
      chk({tag, "_lat1"}, 32'(out_vld), 0);
      @(negedge clk);
      #1;
      chk({tag, "_lat2"}, 32'(out_vld), 1);
   endtask

   initial begin
      int          sent;
      int          got;
      logic        fire;
      logic [8:0]  snap;

      rstn      = 1'b0;
      in_vld    = 1'b0;
      out_rdy   = 1'b1;
      isFls     = 1'b0;
      csc_ycocg = 1'b0;
      mpp_step  = '0;
      qres_ssm  = '0;
      prev_rec  = '0;
      snap      = '0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_vld", 32'(out_vld), 0);
      chk("rst_blk_cnt", 32'(blk_cnt), 0);
      chk("rst_rec", 32'(|rec), 0);
      rstn = 1'b1;
      #1;
      chk("rst_in_rdy", 32'(in_rdy), 1);
      @(negedge clk);
      #1;

      isFls = 1'b1;
      csc_ycocg = 1'b0;
      fill_q(8'h00);
      mpp_step = 3'd0;
      blk("fls_rgb");
      chk("fls_rgb_c0", 32'(rs(0, 0)), 128);
      chk("fls_rgb_c1", 32'(rs(1, 5)), 256);
      chk("fls_rgb_c3", 32'(rs(3, 15)), 256);
      chk("cnt1", 32'(blk_cnt), 1);

      csc_ycocg = 1'b1;
      blk("fls_ycc");
      chk("fls_ycc_c0", 32'(rs(0, 3)), 128);
      chk("fls_ycc_c2", 32'(rs(2, 0)), 0);

      isFls = 1'b0;
      csc_ycocg = 1'b0;
      fill_p(0, 9'd100);
      fill_p(1, 9'd0);
      fill_p(2, 9'd0);
      fill_p(3, 9'd0);
      fill_q(8'd3);
      mpp_step = 3'd2;
      blk("deq");
      chk("deq_c0s0", 32'(rs(0, 0)), 112);
      chk("deq_c0s10", 32'(rs(0, 10)), 112);
      chk("deq_c2s7", 32'(rs(2, 7)), 12);

      fill_q(8'h80);
      mpp_step = 3'd7;
      blk("neg");
      chk("neg_c0", 32'(rs(0, 5)), 0);
      chk("neg_c1", 32'(rs(1, 1)), 0);

      csc_ycocg = 1'b1;
      fill_p(1, 9'h138);
      fill_p(2, 9'h138);
      fill_q(8'h9C);
      mpp_step = 3'd3;
      blk("ycc_lo");
      chk("ycc_lo_c1", 32'(rs(1, 0)), 32'h100);
      chk("ycc_lo_c2", 32'(rs(2, 9)), 32'h100);
      chk("ycc_lo_c0", 32'(rs(0, 2)), 0);

      fill_q(8'h7F);
      mpp_step = 3'd7;
      blk("ycc_hi");
      chk("ycc_hi_c1", 32'(rs(1, 4)), 32'h0FF);
      chk("ycc_hi_c0", 32'(rs(0, 0)), 32'h0FF);

      fill_p(1, 9'h1FF);
      prev_rec[16*CW +: CW] = 9'h000;
      fill_q(8'h00);
      mpp_step = 3'd0;
      blk("floor");
      chk("floor_c1", 32'(rs(1, 8)), 32'h1FF);
      chk("floor_c0", 32'(rs(0, 0)), 100);

      isFls = 1'b1;
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < 16; k++)
            qres_ssm[(s*16+k)*8 +: 8] =
               8'((s == 0) ? k : 16*s + k);
      blk("remap");
      chk("remap_c1s0", 32'(rs(1, 0)), 4);
      chk("remap_c1s3", 32'(rs(1, 3)), 7);
      chk("remap_c1s4", 32'(rs(1, 4)), 32);
      chk("remap_c3s0", 32'(rs(3, 0)), 12);
      chk("remap_c0s4", 32'(rs(0, 4)), 144);
      chk("remap_c3s15", 32'(rs(3, 15)), 75);
      chk("cnt8", 32'(blk_cnt), 8);

      in_vld = 1'b0;
      out_rdy = 1'b1;
      repeat (2) @(negedge clk);
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         out_rdy = !(cyc >= 3 && cyc <= 6);
         in_vld  = (sent < 5);
         fill_q(8'((sent + 1) * 10));
         #1;
         if (cyc >= 3 && cyc <= 6)
            chk("bp_rdy_low", 32'(in_rdy), 0);
         if (cyc >= 4 && cyc <= 6) begin
            chk("bp_hold_vld", 32'(out_vld), 1);
            chk("bp_hold_rec", 32'(rs(1, 0)), 32'(snap));
         end
         if (cyc == 3)
            snap = rs(1, 0);
         if (out_vld && out_rdy) begin
            got++;
            chk("bp_order", 32'(rs(1, 0)), 32'(got * 10));
            chk("bp_c2", 32'(rs(2, 15)), 32'(got * 10));
         end
         fire = in_vld && in_rdy;
         @(negedge clk);
         if (fire)
            sent++;
      end
      chk("bp_got", 32'(got), 5);
      chk("bp_sent", 32'(sent), 5);
      chk("cnt13", 32'(blk_cnt), 13);

      in_vld  = 1'b1;
      out_rdy = 1'b0;
      fill_q(8'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("mid_vld", 32'(out_vld), 1);
      chk("mid_rdy", 32'(in_rdy), 0);
      in_vld = 1'b0;
      #1;
      rstn = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(out_vld), 0);
      chk("mid_rst_cnt", 32'(blk_cnt), 0);
      chk("mid_rst_rdy", 32'(in_rdy), 1);
      chk("mid_rst_rec", 32'(|rec), 0);
      @(negedge clk);
      rstn = 1'b1;
      out_rdy = 1'b1;
      @(negedge clk);

      in_vld = 1'b1;
      repeat (65535) @(negedge clk);
      in_vld = 1'b0;
      #1;
      chk("wrap_pre", 32'(blk_cnt), 32'hFFFF);
      in_vld = 1'b1;
      @(negedge clk);
      in_vld = 1'b0;
      #1;
      chk("wrap_zero", 32'(blk_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decmpp_gen.md
Name: decmpp_gen

Overview:
- Next-generation midpoint-prediction (MPP) reconstruction for the VDC-M decoder; sits after the substream demuxers and before the reconstruction buffer.
- Remaps quantised residuals from NUM_COMP+1 substreams into per-component 16-sample blocks.
- Per component: computes the midpoint from the previous reconstructed block, dequantises with a per-block step, and clips to the component range.
- Generalises the earlier fixed 3-component, free-running design: 3 or 4 components, signed/unsigned chroma mode, 2-stage valid/ready pipeline with backpressure.

Parameters:
BPC, 8, luma/comp0 bit depth; chroma depth is BPC+1.
NUM_COMP, 3, component count; legal values 3 or 4.
NUM_SSM, NUM_COMP+1, substream count (derived; not overridable).

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous active-low reset.
in_vld  in  1  block valid.
in_rdy  out  1  block accepted when in_vld&in_rdy.
isFls  in  1  block is in first line of slice; no usable previous block.
csc_ycocg  in  1  1: chroma signed YCoCg range; 0: unsigned RGB range.
mpp_step  in  3  dequant left shift, 0..7.
qres_ssm  in  NUM_SSM*16*8  signed 8b residuals; substream s, entry j at bits [(s*16+j)*8 +: 8].
prev_rec  in  NUM_COMP*16*(BPC+1)  previous block reconstruction; comp c, sample n at [(c*16+n)*(BPC+1) +: BPC+1]; comp0 uses low BPC bits.
out_vld  out  1  reconstructed block valid.
out_rdy  in  1  downstream accepts.
rec  out  NUM_COMP*16*(BPC+1)  reconstruction, same packing as prev_rec; comp0 zero-extended.
blk_cnt  out  16  number of accepted input blocks.

Behaviour:
- Reset: out_vld=0, internal stage-1 valid=0, blk_cnt=0, rec=0. in_rdy is combinational and therefore reads 1 after reset.
- Remap, comp c, sample n:
  - n<4: ssm0 entry 4c+n.
  - n>=4: ssm(c+1) entry n-4.
  - With NUM_COMP=3, ssm0 entries 12..15 are ignored.
- Stage 1, registered on accept: remapped residuals, isFls, csc_ycocg, mpp_step, and per-component midpoint mp.
  - mp when isFls=1: comp0 = 2^(BPC-1); chroma = 0 if csc_ycocg else 2^BPC.
  - mp when isFls=0: floor of the sum of the 16 prev_rec samples divided by 16. The sum is 4 bits wider than the sample; sample interpretation follows the range in force (signed for YCoCg chroma).
- Stage 2, registered output:
  - v = mp + (sext(qres) << mpp_step), computed at BPC+12 bits signed with no overflow.
  - Clip comp0 to [0, 2^BPC-1].
  - Clip chroma to [-2^BPC, 2^BPC-1] if YCoCg, else [0, 2^(BPC+1)-1].
  - Signed chroma is output in two's complement, BPC+1 bits.
- Latency: 2 cycles from accept to out_vld with no stall.
- Handshake and backpressure:
  - Stage 2 loads when ~out_vld | out_rdy.
  - Stage 1 advances when stage 2 loads or stage 1 is empty.
  - in_rdy = ~s1_vld | stage-2-load.
  - Full throughput of one block per cycle when out_rdy=1.
  - While out_vld=1 and out_rdy=0, rec and out_vld hold stable; at most 2 blocks are in flight.
- in_vld=1 with in_rdy=0: inputs are not sampled; the source must hold them.
- Simultaneous accept and output in the same cycle is legal and loses no block.
- blk_cnt increments on each accept and wraps 0xFFFF->0.
- Reset asserted mid-operation discards in-flight blocks immediately and asynchronously.
- Parameters are checked at elaboration: NUM_COMP outside {3,4} is a fatal error.

Decomposition:
- Shared package decmpp_pkg: qres width (8), block size (16), lane offset constants (SSM0_LANES=4), and the midpoint and clip-bound functions parametrised by depth and signedness.
- One sub-module, decmpp_lane: one component's midpoint, dequant and clip pipeline, parametrised by depth and is_chroma. Instantiated NUM_COMP times; it carries no handshake logic.
- The top level owns the remap, the valid/ready control and blk_cnt.

Test Plan:
- isFls=1, BPC=8, all qres=0, step=0 -> comp0=128, chroma=256 (RGB) or 0 (YCoCg); out_vld 2 cycles after accept.
- isFls=0, comp0 prev all 100, qres=+3, step=2 -> comp0 rec=112; qres=-128, step=7 -> clipped to 0.
- YCoCg chroma prev all -200, qres=-100, step=3 -> clipped to -256 (0x100); qres=+127, step=7 -> clipped to 255.
- Remap: set ssm0 entry k=k, ssm(s) entry k=16s+k, step=0, isFls=1, YCoCg -> comp1 samples 0..3 = 4..7; comp1 sample 4 = 32. NUM_COMP=4: comp3 sample 0 = 12.
- Backpressure: stream 5 blocks, out_rdy low for cycles 3..6 -> in_rdy drops after 2 blocks in flight, outputs in order with none lost or duplicated, rec stable while stalled.
- Reset mid-stream with 2 blocks in flight -> out_vld=0, blk_cnt=0 immediately; blk_cnt wraps 0xFFFF->0 on the next accept after preload by 65535 accepts.
